// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler: picks one eligible warp per cycle and tracks
// per-warp branch holds and a running issue count.

module warp_lane (
  input  logic clk,
  input  logic rst,
  input  logic warp_active,
  input  logic ibuf_valid,
  input  logic ibuf_is_branch,
  input  logic scb_full,
  input  logic scb_dependent,
  input  logic granted,
  input  logic resolve,
  output logic elig,
  output logic hold
);

  // A branch issuing this cycle outranks a resolve aimed at the same warp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           hold <= 1'b0;
    else if (granted && ibuf_is_branch) hold <= 1'b1;
    else if (resolve)                  hold <= 1'b0;
  end

  assign elig = warp_active & ibuf_valid & ~scb_full & ~scb_dependent & ~hold;

endmodule

module warp_issue_scheduler #(
  parameter int NUM_WARPS     = 8,
  parameter int LOG_NUM_WARPS = $clog2(NUM_WARPS),
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WARPS-1:0]     ibuf_valid,
  input  logic [NUM_WARPS-1:0]     ibuf_is_branch,
  input  logic [NUM_WARPS-1:0]     warp_active,
  input  logic [NUM_WARPS-1:0]     scb_full,
  input  logic [NUM_WARPS-1:0]     scb_dependent,
  input  logic                     oc_ready,
  input  logic                     branch_resolve_valid,
  input  logic [LOG_NUM_WARPS-1:0] branch_resolve_warp,
  output logic [NUM_WARPS-1:0]     issue_grant,
  output logic                     issue_valid,
  output logic [LOG_NUM_WARPS-1:0] issue_warp_id,
  output logic [NUM_WARPS-1:0]     branch_hold,
  output logic [CNT_W-1:0]         issue_count
);

  logic [NUM_WARPS-1:0]     elig;
  logic [LOG_NUM_WARPS-1:0] rr_ptr;
  logic [LOG_NUM_WARPS-1:0] win;
  logic                     found;
  logic                     grant;
  logic [LOG_NUM_WARPS:0]   idx;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_lane
    warp_lane u_lane (
      .clk            (clk),
      .rst            (rst),
      .warp_active    (warp_active[g]),
      .ibuf_valid     (ibuf_valid[g]),
      .ibuf_is_branch (ibuf_is_branch[g]),
      .scb_full       (scb_full[g]),
      .scb_dependent  (scb_dependent[g]),
      .granted        (issue_grant[g]),
      // IDs >= NUM_WARPS match no lane and are therefore ignored.
      .resolve        (branch_resolve_valid && (branch_resolve_warp == LOG_NUM_WARPS'(g))),
      .elig           (elig[g]),
      .hold           (branch_hold[g])
    );
  end

  // Rotating search starting at rr_ptr; idx carries one extra bit so the wrap
  // works for non power-of-two warp counts.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = {1'b0, rr_ptr} + (LOG_NUM_WARPS+1)'(i);
      if (idx >= (LOG_NUM_WARPS+1)'(NUM_WARPS)) idx = idx - (LOG_NUM_WARPS+1)'(NUM_WARPS);
      if (!found && elig[idx[LOG_NUM_WARPS-1:0]]) begin
        found = 1'b1;
        win   = idx[LOG_NUM_WARPS-1:0];
      end
    end
  end

  assign grant         = oc_ready && found && !rst;
  assign issue_valid   = grant;
  assign issue_warp_id = grant ? win : '0;
  assign issue_grant   = grant ? (NUM_WARPS'(1) << win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      issue_count <= '0;
    end else if (grant) begin
      rr_ptr      <= (win == LOG_NUM_WARPS'(NUM_WARPS-1)) ? '0 : win + 1'b1;
      issue_count <= issue_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: directed vector table, hand sequences, and
// randomized traffic against a plain-arithmetic reference model.

module tb_warp_issue_scheduler;

  localparam int N  = 8;
  localparam int LW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ibuf_valid, ibuf_is_branch, warp_active, scb_full, scb_dependent;
  logic          oc_ready, branch_resolve_valid;
  logic [LW-1:0] branch_resolve_warp;
  logic [N-1:0]  issue_grant, branch_hold;
  logic          issue_valid;
  logic [LW-1:0] issue_warp_id;
  logic [CW-1:0] issue_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int           m_rr;
  logic [N-1:0] m_hold;
  int           m_cnt;

  always #5 clk = ~clk;

  warp_issue_scheduler #(.NUM_WARPS(N), .LOG_NUM_WARPS(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ibuf_valid(ibuf_valid), .ibuf_is_branch(ibuf_is_branch), .warp_active(warp_active),
    .scb_full(scb_full), .scb_dependent(scb_dependent), .oc_ready(oc_ready),
    .branch_resolve_valid(branch_resolve_valid), .branch_resolve_warp(branch_resolve_warp),
    .issue_grant(issue_grant), .issue_valid(issue_valid), .issue_warp_id(issue_warp_id),
    .branch_hold(branch_hold), .issue_count(issue_count)
  );

  typedef struct {
    logic [N-1:0]  v, act, br, full, dep;
    logic          oc, rv;
    logic [LW-1:0] rw;
    logic          ev;
    logic [LW-1:0] eid;
    logic [N-1:0]  ehold;
  } vec_t;

  vec_t tbl[35];

  function automatic vec_t mk(logic [7:0] v, logic [7:0] act, logic [7:0] br, logic [7:0] full,
                              logic [7:0] dep, logic oc, logic rv, logic [2:0] rw,
                              logic ev, logic [2:0] eid, logic [7:0] ehold);
    vec_t r;
    r.v = v; r.act = act; r.br = br; r.full = full; r.dep = dep; r.oc = oc;
    r.rv = rv; r.rw = rw; r.ev = ev; r.eid = eid; r.ehold = ehold;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First eligible warp in circular order from the model pointer, or -1.
  function automatic int pick();
    int w;
    if (!oc_ready) return -1;
    for (int k = 0; k < N; k++) begin
      w = (m_rr + k) % N;
      if (warp_active[w] && ibuf_valid[w] && !scb_full[w] && !scb_dependent[w] && !m_hold[w])
        return w;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_hold = '0; m_cnt = 0;
  endtask

  // Compare this cycle's outputs to the model, then advance one clock.
  task automatic step();
    int w;
    logic br_w;
    #1;
    w = pick();
    chk("issue_valid", 32'(issue_valid), (w >= 0) ? 32'd1 : 32'd0);
    chk("issue_warp_id", 32'(issue_warp_id), (w >= 0) ? 32'(w) : 32'd0);
    chk("issue_grant", 32'(issue_grant), (w >= 0) ? (32'd1 << w) : 32'd0);
    chk("branch_hold", 32'(branch_hold), 32'(m_hold));
    chk("issue_count", 32'(issue_count), 32'(m_cnt));
    br_w = (w >= 0) ? ibuf_is_branch[w] : 1'b0;
    @(posedge clk);
    if (branch_resolve_valid && int'(branch_resolve_warp) < N) m_hold[branch_resolve_warp] = 1'b0;
    if (w >= 0) begin
      if (br_w) m_hold[w] = 1'b1;
      m_rr  = (w + 1) % N;
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    @(negedge clk);
  endtask

  task automatic all_elig();
    ibuf_valid = '1; warp_active = '1; ibuf_is_branch = '0; scb_full = '0; scb_dependent = '0;
    oc_ready = 1'b1; branch_resolve_valid = 1'b0; branch_resolve_warp = '0;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = mk(8'hFF, 8'hFF, 0, 0, 0, 1, 0, 0, 1, 3'(i % 8), 0);
    for (int i = 0; i < 4; i++)  tbl[10+i] = mk(8'hFF, 8'hFF, 0, 0, 0, 1, 0, 0, 1, 3'(2 + i), 0);
    tbl[14] = mk(8'h24, 8'hFF, 0,     0,     0,     1, 0, 0, 1, 2, 0);
    tbl[15] = mk(8'h24, 8'hFF, 0,     0,     0,     1, 0, 0, 1, 5, 0);
    tbl[16] = mk(8'h08, 8'hFF, 0,     0,     8'h08, 1, 0, 0, 0, 0, 0);
    tbl[17] = mk(8'h08, 8'hFF, 0,     8'h08, 0,     1, 0, 0, 0, 0, 0);
    tbl[18] = mk(8'h08, 8'hFF, 0,     0,     0,     1, 0, 0, 1, 3, 0);
    tbl[19] = mk(8'h10, 8'hFF, 8'h10, 0,     0,     1, 0, 0, 1, 4, 0);
    tbl[20] = mk(8'h10, 8'hFF, 0,     0,     0,     1, 0, 0, 0, 0, 8'h10);
    tbl[21] = mk(8'h10, 8'hFF, 0,     0,     0,     1, 1, 4, 0, 0, 8'h10);
    tbl[22] = mk(8'h10, 8'hFF, 0,     0,     0,     1, 0, 0, 1, 4, 0);
    tbl[23] = mk(8'h10, 8'hFF, 8'h10, 0,     0,     1, 0, 0, 1, 4, 0);
    tbl[24] = mk(8'h40, 8'hFF, 8'h40, 0,     0,     1, 1, 4, 1, 6, 8'h10);
    tbl[25] = mk(8'h00, 8'hFF, 0,     0,     0,     1, 1, 2, 0, 0, 8'h40);
    tbl[26] = mk(8'h00, 8'hFF, 0,     0,     0,     1, 1, 6, 0, 0, 8'h40);
    tbl[27] = mk(8'hFF, 8'h00, 0,     0,     0,     1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tbl[28+i] = mk(8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[33] = mk(8'hFF, 8'hFF, 0,     0,     0,     1, 0, 0, 1, 7, 0);
    tbl[34] = mk(8'hFF, 8'hFF, 0,     0,     0,     1, 0, 0, 1, 0, 0);

    // reset held with every warp eligible
    all_elig();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_grant", 32'(issue_grant), 0);
    chk("rst_id", 32'(issue_warp_id), 0);
    chk("rst_hold", 32'(branch_hold), 0);
    chk("rst_count", 32'(issue_count), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      ibuf_valid = tbl[i].v; warp_active = tbl[i].act; ibuf_is_branch = tbl[i].br;
      scb_full = tbl[i].full; scb_dependent = tbl[i].dep; oc_ready = tbl[i].oc;
      branch_resolve_valid = tbl[i].rv; branch_resolve_warp = tbl[i].rw;
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(issue_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_id", i), 32'(issue_warp_id), 32'(tbl[i].eid));
      chk($sformatf("tbl%0d_grant", i), 32'(issue_grant), tbl[i].ev ? (32'd1 << tbl[i].eid) : 32'd0);
      chk($sformatf("tbl%0d_hold", i), 32'(branch_hold), 32'(tbl[i].ehold));
      step();
    end
    chk("tbl_count", 32'(issue_count), 23);

    // hazard flag dropped mid-cycle grants in that same cycle
    all_elig();
    ibuf_valid = 8'h08; scb_dependent = 8'h08;
    #1;
    chk("dep_hold_off", 32'(issue_valid), 0);
    scb_dependent = 8'h00;
    #1;
    chk("dep_drop_valid", 32'(issue_valid), 1);
    chk("dep_drop_id", 32'(issue_warp_id), 3);
    step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      ibuf_valid           = N'($urandom);
      warp_active          = N'($urandom) | N'($urandom);
      scb_full             = N'($urandom) & N'($urandom) & N'($urandom);
      scb_dependent        = N'($urandom) & N'($urandom);
      ibuf_is_branch       = N'($urandom) & N'($urandom);
      oc_ready             = ($urandom_range(0, 4) != 0);
      branch_resolve_valid = ($urandom_range(0, 2) == 0);
      branch_resolve_warp  = LW'($urandom);
      step();
    end

    // clear every hold with the collector stalled, then drive the counter to its top
    all_elig();
    oc_ready = 1'b0;
    branch_resolve_valid = 1'b1;
    for (int w = 0; w < N; w++) begin
      branch_resolve_warp = LW'(w);
      step();
    end
    all_elig();
    for (int k = 0; k < 70000 && m_cnt != 65535; k++) step();
    #1;
    chk("count_ffff", 32'(issue_count), 32'hFFFF);
    step();
    #1;
    chk("count_wrap", 32'(issue_count), 0);

    // reset asserted mid-operation kills the grant immediately
    all_elig();
    ibuf_is_branch = 8'h01;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(issue_valid), 0);
    chk("midrst_grant", 32'(issue_grant), 0);
    chk("midrst_count", 32'(issue_count), 0);
    chk("midrst_hold", 32'(branch_hold), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ibuf_is_branch = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
